img_pixel_pack_writer: RTL and testbench
========================================

IMG_PIXEL_PACK_WRITER -- requirements
Module: img_pixel_pack_writer

Interface
REQ-001 Parameter: ADDR_W, default 14, memory word-address width.
REQ-002 Parameter: MEM_WORDS, default 10000, number of 32-bit words in the target on-chip memory.
REQ-003 Parameter: LEN_W, default 16, width of the pixel-count input.
REQ-004 Port: clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle pulse that begins a transfer.
REQ-007 Port: base_addr  input  ADDR_W  first word address; sampled on start.
REQ-008 Port: num_pixels  input  LEN_W  number of pixels to write; sampled on start.
REQ-009 Port: busy  output  1  a transfer is in progress.
REQ-010 Port: done  output  1  sticky completion flag; cleared by an accepted start.
REQ-011 Port: err  output  1  sticky range-error flag; cleared by an accepted start.
REQ-012 Port: snk_data  input  8  pixel data on the Avalon-ST sink.
REQ-013 Port: snk_valid  input  1  sink valid.
REQ-014 Port: snk_ready  output  1  sink ready.
REQ-015 Port: mem_address, mem_byteenable[3:0], mem_chipselect, mem_write, mem_writedata[31:0]  outputs  Avalon-MM write master that drives the single-port on-chip memory slave; there is no waitrequest.

Function
REQ-016 States: IDLE, PACK, FLUSH, DONE.
REQ-017 IDLE + start -> range check: if num_pixels==0, go to DONE with no writes; if base_addr + ceil(num_pixels/4) > MEM_WORDS, set err, stay in IDLE with no writes; otherwise latch the inputs, set busy, go to PACK.
REQ-018 start while busy is ignored.
REQ-019 snk_ready = 1 only in PACK; a pixel is accepted on any cycle where snk_valid & snk_ready.
REQ-020 Pixel k of a word goes into byte lane k (bits 8k+7:8k), little-endian; the first pixel of a transfer is lane 0.
REQ-021 On acceptance of a lane-3 pixel, the word is registered to mem_writedata with byteenable 4'b1111; mem_write and mem_chipselect are high for exactly the next cycle.
REQ-022 Throughput: one pixel per cycle sustained; snk_ready is not dropped while a write is issuing.
REQ-023 mem_address starts at base_addr and increments by 1 after each write.
REQ-024 When the last pixel is accepted on lane L<3: go to FLUSH and issue one write with byteenable bits 0..L set; the unused lanes of writedata are 0.
REQ-025 After the final write cycle, busy falls and done rises on the same edge; state goes DONE.
REQ-026 DONE behaves as IDLE for start; done holds until the next accepted start.
REQ-027 When no write is issuing, mem_write = mem_chipselect = 0 and mem_byteenable = 0.
REQ-028 Total writes per transfer = ceil(num_pixels/4); the address never exceeds base_addr + ceil(num_pixels/4) - 1.

Reset
REQ-029 reset asserted at any time, including mid-transfer, forces IDLE and drives busy, done, err, snk_ready, mem_write, mem_chipselect = 0; mem_address, mem_byteenable, mem_writedata = 0; the pack register = 0.
REQ-030 A partially packed word is discarded on reset; no flush occurs.

Configuration
REQ-031 Macro IMG_PACK_WRITER_IRQ_EN defined: adds output irq (1 bit) = done | err, level, cleared by an accepted start.
REQ-032 Macro not defined: the irq port does not exist; all other behaviour is identical.

Structure
REQ-033 Shared package img_pp_pkg holds the state enum, MEM_WORDS_DEFAULT = 10000, and PIX_PER_WORD = 4.
REQ-034 One sub-module, img_byte_packer, does the lane steering, word assembly and byteenable generation; the top level holds the FSM, counters and address logic.

Verification
REQ-035 base=0x0100, num=8, pixels 0x01..0x08 back-to-back -> writes at 0x0100 = 0x04030201 and 0x0101 = 0x08070605, BE=F; done 1 cycle after the 2nd write.
REQ-036 base=0x0000, num=6 -> 2nd write at 0x0001 with data 0x00000605 and BE=4'b0011.
REQ-037 base=9998, num=12 (3 words) -> err=1, no mem_write, busy stays 0; base=9997, num=12 -> 3 writes, last at 9999.
REQ-038 num=0 -> done on the next cycle, zero writes; start pulsed during busy -> ignored, the transfer completes unchanged.
REQ-039 snk_valid toggled 1010... for num=4 -> a single write of the correct word; reset asserted after 2 pixels -> all outputs 0, no write; a new start then runs cleanly.
REQ-040 With IMG_PACK_WRITER_IRQ_EN: irq rises with done, falls on the next start; without the macro the bench compiles without the irq port.

Source files
------------

// File: rtl/img_pp_pkg.sv
// Shared types and constants for the pixel pack writer: FSM states, packing geometry,
// and the byte-enable helper.
package img_pp_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 10000;
    localparam int unsigned PIX_PER_WORD      = 4;
    localparam int unsigned LANE_W            = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pp_state_e;

    // Byte enables for lanes 0..lane inclusive.
    function automatic logic [PIX_PER_WORD-1:0] lane_be(input logic [LANE_W-1:0] lane);
        logic [PIX_PER_WORD-1:0] be;
        be = '0;
        for (int i = 0; i < int'(PIX_PER_WORD); i++) begin
            be[i] = (i <= int'(lane));
        end
        return be;
    endfunction

endpackage

// File: rtl/img_byte_packer.sv
// Steers incoming pixels into byte lanes and assembles 32-bit words; reports when a word
// (full, or partial on the last pixel) is ready along with its byte enables.
module img_byte_packer
    import img_pp_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     accept,
    input  logic                     last,
    input  logic [7:0]               pix,
    output logic                     emit_c,
    output logic [31:0]              word_c,
    output logic [PIX_PER_WORD-1:0]  be_c
);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [31:0]       pack_q, pack_d;

    always_comb begin
        lane_d = lane_q;
        pack_d = pack_q;
        word_c = pack_q | (32'(pix) << {lane_q, 3'b000});
        be_c   = lane_be(lane_q);
        emit_c = accept && ((lane_q == LANE_W'(PIX_PER_WORD - 1)) || last);
        if (clear) begin
            lane_d = '0;
            pack_d = '0;
        end else if (accept) begin
            // Emitted words leave the pack register empty so unused lanes read as zero.
            if (emit_c) begin
                lane_d = '0;
                pack_d = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
                pack_d = word_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/img_pixel_pack_writer.sv
// Packs an 8-bit Avalon-ST pixel stream into 32-bit words and writes them to on-chip memory
// through an Avalon-MM master. Optional irq output when IMG_PACK_WRITER_IRQ_EN is defined.
module img_pixel_pack_writer
    import img_pp_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int unsigned LEN_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_pixels,
    output logic              busy,
    output logic              done,
    output logic              err,
`ifdef IMG_PACK_WRITER_IRQ_EN
    output logic              irq,
`endif
    input  logic [7:0]        snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata
);

    localparam int unsigned SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 2;

    pp_state_e         state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;
    logic              wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
`ifdef IMG_PACK_WRITER_IRQ_EN
    logic              irq_q, irq_d;
`endif

    logic              start_acc_c;
    logic              accept_c;
    logic              last_c;
    logic              range_err_c;
    logic [SUM_W-1:0]  words_c;
    logic [SUM_W-1:0]  end_c;
    logic              emit_c;
    logic [31:0]       word_c;
    logic [3:0]        pk_be_c;

    img_byte_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_acc_c),
        .accept (accept_c),
        .last   (last_c),
        .pix    (snk_data),
        .emit_c (emit_c),
        .word_c (word_c),
        .be_c   (pk_be_c)
    );

    // Range check uses a widened sum so base + word count cannot wrap.
    always_comb begin
        words_c     = (SUM_W'(num_pixels) + SUM_W'(PIX_PER_WORD - 1)) >> LANE_W;
        end_c       = SUM_W'(base_addr) + words_c;
        range_err_c = (end_c > SUM_W'(MEM_WORDS));
        start_acc_c = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        accept_c    = (state_q == ST_PACK) && snk_valid;
        last_c      = accept_c && (cnt_q == LEN_W'(1));
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        be_d    = 4'b0000;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc_c) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    if (num_pixels == '0) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (range_err_c) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = base_addr;
                        cnt_d   = num_pixels;
                        busy_d  = 1'b1;
                        state_d = ST_PACK;
                    end
                end
            end
            ST_PACK: begin
                // Advance after each non-final write so the last address is never exceeded.
                if (wr_q) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
                if (accept_c) begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
                if (emit_c) begin
                    wr_d    = 1'b1;
                    be_d    = pk_be_c;
                    wdata_d = word_c;
                end
                if (last_c) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_PACK);
`ifdef IMG_PACK_WRITER_IRQ_EN
        irq_d = done_d | err_d;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
`ifdef IMG_PACK_WRITER_IRQ_EN
            irq_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
`ifdef IMG_PACK_WRITER_IRQ_EN
            irq_q   <= irq_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign snk_ready      = ready_q;
    assign mem_write      = wr_q;
    assign mem_chipselect = wr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign mem_address    = addr_q;
`ifdef IMG_PACK_WRITER_IRQ_EN
    assign irq            = irq_q;
`endif

endmodule

// File: tb/tb_img_pixel_pack_writer.sv
// Self-checking bench for img_pixel_pack_writer; expected memory writes come from a
// word-level model of the packing rules. Checks irq when IMG_PACK_WRITER_IRQ_EN is defined.
module tb_img_pixel_pack_writer;

    localparam int MEMW = 10000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] base_addr = '0;
    logic [15:0] num_pixels = '0;
    logic        busy, done, err;
`ifdef IMG_PACK_WRITER_IRQ_EN
    logic        irq;
`endif
    logic [7:0]  snk_data = '0;
    logic        snk_valid = 1'b0;
    logic        snk_ready;
    logic [13:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata;

    img_pixel_pack_writer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .num_pixels     (num_pixels),
        .busy           (busy),
        .done           (done),
        .err            (err),
`ifdef IMG_PACK_WRITER_IRQ_EN
        .irq            (irq),
`endif
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Bus monitor: logs every write cycle and counts illegal idle-bus states.
    int unsigned cyc = 0;
    int unsigned viol = 0;
    logic [13:0] log_addr[$];
    logic [3:0]  log_be[$];
    logic [31:0] log_data[$];
    int unsigned log_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            log_addr.push_back(mem_address);
            log_be.push_back(mem_byteenable);
            log_data.push_back(mem_writedata);
            log_cyc.push_back(cyc);
        end
        if ((mem_chipselect !== mem_write) ||
            ((mem_write !== 1'b1) && (mem_byteenable !== 4'b0000)))
            viol <= viol + 1;
    end

    logic [7:0] pix_buf [64];
    int         last_w0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic eb, input logic ed, input logic ee);
        check({tag, "_busy"}, 32'(busy), 32'(eb));
        check({tag, "_done"}, 32'(done), 32'(ed));
        check({tag, "_err"},  32'(err),  32'(ee));
`ifdef IMG_PACK_WRITER_IRQ_EN
        check({tag, "_irq"},  32'(irq),  32'(ed | ee));
`endif
    endtask

    task automatic fill_random(input int num);
        for (int i = 0; i < num; i++) pix_buf[i] = 8'($urandom_range(0, 255));
    endtask

    // vmode: 0 back-to-back, 1 toggling 1010, 2 random valid. poke pulses start mid-transfer.
    task automatic run_xfer(input string tag, input logic [13:0] base, input int num,
                            input int vmode, input bit poke);
        int exp_words, w0, v0, idx, cnt, done_cyc, p;
        bit range_err, got_done, v;
        logic [31:0] ew;
        logic [3:0]  eb;
        exp_words = (num + 3) / 4;
        range_err = (num != 0) && (int'(base) + exp_words > MEMW);
        w0 = log_addr.size();
        last_w0 = w0;
        v0 = int'(viol);
        start = 1'b1;
        base_addr = base;
        num_pixels = 16'(num);
        @(negedge clk);
        start = 1'b0;
        if (num == 0) begin
            check_flags({tag, "_zero"}, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            check({tag, "_zero_writes"}, 32'(log_addr.size() - w0), 32'd0);
            return;
        end
        if (range_err) begin
            check_flags({tag, "_rerr"}, 1'b0, 1'b0, 1'b1);
            repeat (3) @(negedge clk);
            check_flags({tag, "_rerr_hold"}, 1'b0, 1'b0, 1'b1);
            check({tag, "_rerr_ready"}, 32'(snk_ready), 32'd0);
            check({tag, "_rerr_writes"}, 32'(log_addr.size() - w0), 32'd0);
            return;
        end
        check_flags({tag, "_go"}, 1'b1, 1'b0, 1'b0);
        check({tag, "_go_ready"}, 32'(snk_ready), 32'd1);
        idx = 0;
        cnt = 0;
        got_done = 1'b0;
        done_cyc = 0;
        while (!got_done && cnt < 20 * num + 50) begin
            if (idx < num) begin
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (cnt % 2 == 0);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                snk_valid = v;
                snk_data = pix_buf[idx];
                if (v && snk_ready === 1'b1) idx++;
            end else begin
                snk_valid = 1'b0;
            end
            if (poke && cnt == 3) begin
                start = 1'b1;
                base_addr = 14'h0;
                num_pixels = 16'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cnt++;
            if (done === 1'b1) begin
                got_done = 1'b1;
                done_cyc = int'(cyc);
            end
        end
        snk_valid = 1'b0;
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(got_done), 32'd1);
        check_flags({tag, "_end"}, 1'b0, 1'b1, 1'b0);
        check({tag, "_end_ready"}, 32'(snk_ready), 32'd0);
        check({tag, "_nwrites"}, 32'(log_addr.size() - w0), 32'(exp_words));
        for (int w = 0; w < exp_words && (w0 + w) < log_addr.size(); w++) begin
            ew = '0;
            eb = '0;
            for (int k = 0; k < 4; k++) begin
                p = 4 * w + k;
                if (p < num) begin
                    ew = ew | (32'(pix_buf[p]) << (8 * k));
                    eb[k] = 1'b1;
                end
            end
            check($sformatf("%s_w%0d_addr", tag, w), 32'(log_addr[w0 + w]), 32'(int'(base) + w));
            check($sformatf("%s_w%0d_be", tag, w), 32'(log_be[w0 + w]), 32'(eb));
            check($sformatf("%s_w%0d_data", tag, w), log_data[w0 + w], ew);
        end
        if (log_addr.size() > w0)
            check({tag, "_done_lat"}, 32'(done_cyc), 32'(log_cyc[log_addr.size() - 1] + 1));
        check({tag, "_addr_max"}, 32'(mem_address), 32'(int'(base) + exp_words - 1));
        check({tag, "_bus_idle"}, 32'(int'(viol) - v0), 32'd0);
    endtask

    initial begin
        int w0;
        // Reset state
        repeat (2) @(negedge clk);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        check("rst_ready", 32'(snk_ready), 32'd0);
        check("rst_wr", 32'(mem_write), 32'd0);
        check("rst_cs", 32'(mem_chipselect), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_be", 32'(mem_byteenable), 32'd0);
        check("rst_wdata", mem_writedata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Two full words, back-to-back
        for (int i = 0; i < 8; i++) pix_buf[i] = 8'(i + 1);
        run_xfer("t8", 14'h0100, 8, 0, 1'b0);
        check("t8_w0_const", log_data[last_w0], 32'h04030201);
        check("t8_w1_const", log_data[last_w0 + 1], 32'h08070605);

        // Partial last word
        for (int i = 0; i < 6; i++) pix_buf[i] = 8'(i + 1);
        run_xfer("t6", 14'h0000, 6, 0, 1'b0);
        check("t6_w1_const", log_data[last_w0 + 1], 32'h00000605);
        check("t6_w1_be", 32'(log_be[last_w0 + 1]), 32'h3);

        // Range boundary
        fill_random(12);
        run_xfer("rng_bad", 14'(9998), 12, 0, 1'b0);
        run_xfer("rng_ok", 14'(9997), 12, 2, 1'b0);

        // Zero length, then start while busy
        run_xfer("zero", 14'h0040, 0, 0, 1'b0);
        fill_random(10);
        run_xfer("poke", 14'h0200, 10, 0, 1'b1);

        // Toggling valid
        fill_random(4);
        run_xfer("tog", 14'h0300, 4, 1, 1'b0);

        // Reset mid-transfer after two pixels
        w0 = log_addr.size();
        start = 1'b1;
        base_addr = 14'h0020;
        num_pixels = 16'd4;
        @(negedge clk);
        start = 1'b0;
        snk_valid = 1'b1;
        snk_data = 8'hAA;
        @(negedge clk);
        snk_data = 8'hBB;
        @(negedge clk);
        snk_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_flags("midrst", 1'b0, 1'b0, 1'b0);
        check("midrst_ready", 32'(snk_ready), 32'd0);
        check("midrst_wr", 32'(mem_write), 32'd0);
        check("midrst_addr", 32'(mem_address), 32'd0);
        check("midrst_be", 32'(mem_byteenable), 32'd0);
        check("midrst_wdata", mem_writedata, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_nowrite", 32'(log_addr.size() - w0), 32'd0);
        fill_random(7);
        run_xfer("after_rst", 14'h0020, 7, 0, 1'b0);

        // Randomized transfers
        for (int t = 0; t < 6; t++) begin
            int nb, nn;
            nb = int'($urandom_range(0, 9000));
            nn = int'($urandom_range(1, 40));
            fill_random(nn);
            run_xfer($sformatf("rnd%0d", t), 14'(nb), nn, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
